// File: rtl/regf_initiator_pkg.sv
// Shared types for the regf bus initiator: FSM state, queued command, captured response.
// Latency: n/a (types only).
// Backpressure: n/a. Command/response field widths are fixed here; the top's AW/DW must match them.
package regf_initiator_pkg;

  localparam int unsigned REGF_AW = 13;
  localparam int unsigned REGF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [REGF_AW-1:0] addr;
    logic               wena;
    logic [REGF_DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic               wena;
    logic [REGF_DW-1:0] rdata;
    logic               err;
  } rsp_t;

endpackage

// File: rtl/regf_initiator_fifo.sv
// Command FIFO of cmd_t, show-ahead (head visible on pop_dat while not empty).
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: pushes are dropped while full or in reset; pops are ignored while empty.
// Ports: clk/rst (sync, active-high), push/push_dat/full, pop/pop_dat/empty.
module regf_initiator_fifo
  import regf_initiator_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_dat,
  output logic full,
  input  logic pop,
  output cmd_t pop_dat,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/regf_initiator.sv
// Bus initiator for a regf mem_* port: queued commands, one mem_ena pulse each, in-order responses.
// Latency: cmd handshake cycle 0 -> mem_ena cycle 2 -> rsp_valid cycle 4; 3 cycles/access back-to-back.
// Backpressure: cmd_ready_o = FIFO not full; rsp_ready_i low holds the FSM in RESP with a stable response.
// Ports: cmd_* command stream in, rsp_* response stream out, mem_* regf access port, busy_o status.
// Optional: define REGF_INITIATOR_ERRCNT_EN to add errcnt_o, a saturating count of error responses.
module regf_initiator
  import regf_initiator_pkg::*;
#(
  parameter int unsigned AW    = REGF_AW,
  parameter int unsigned DW    = REGF_DW,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ERRW  = 8
) (
  input  logic          main_clk_i,
  input  logic          main_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic          cmd_wena_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_wena_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          mem_ena_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_wena_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_err_i,
`ifdef REGF_INITIATOR_ERRCNT_EN
  output logic [ERRW-1:0] errcnt_o,
`endif
  output logic          busy_o
);

  state_e state_q;
  state_e state_d;
  cmd_t   fifo_in;
  cmd_t   fifo_head;
  cmd_t   cmd_q;
  rsp_t   rsp_q;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;

  assign fifo_in.addr  = cmd_addr_i;
  assign fifo_in.wena  = cmd_wena_i;
  assign fifo_in.wdata = cmd_wdata_i;

  regf_initiator_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (main_clk_i),
    .rst      (main_rst_i),
    .push     (cmd_valid_i),
    .push_dat (fifo_in),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty)
  );

  assign cmd_ready_o = !fifo_full;

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = REQ;
        end
      end
      REQ:  state_d = WAIT;
      WAIT: state_d = RESP;
      RESP: begin
        // Chain straight into the next access to keep the 3-cycle cadence.
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = REQ;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) cmd_q <= fifo_head;
      if (state_q == WAIT) begin
        rsp_q.wena  <= cmd_q.wena;
        // The target's read bus is meaningless on writes; report zero.
        rsp_q.rdata <= cmd_q.wena ? '0 : mem_rdata_i;
        rsp_q.err   <= mem_err_i;
      end
    end
  end

  assign mem_ena_o   = (state_q == REQ);
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wena_o  = mem_ena_o && cmd_q.wena;
  assign mem_wdata_o = cmd_q.wdata;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_wena_o  = rsp_q.wena;
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;

  assign busy_o = (state_q != IDLE) || !fifo_empty;

`ifdef REGF_INITIATOR_ERRCNT_EN
  logic [ERRW-1:0] errcnt_q;

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      errcnt_q <= '0;
    end else if (rsp_valid_o && rsp_ready_i && rsp_q.err && (errcnt_q != '1)) begin
      errcnt_q <= errcnt_q + 1'b1;
    end
  end

  assign errcnt_o = errcnt_q;
`endif

endmodule

// File: doc/regf_initiator.md
# regf_initiator

Bus initiator that drives the `mem_*` access port of a generated register file (`*_regf`). It accepts read/write commands over a valid/ready stream and buffers them in a small FIFO. It issues each command as a single-cycle `mem_ena` access, captures `mem_rdata`/`mem_err` one cycle later, and returns a response over a second valid/ready stream. It sits between a CPU/test sequencer and any regf instance in the design.

## Interface
Parameters:
- `AW`, 13, address width; matches the regf `mem_addr` width.
- `DW`, 32, data width.
- `DEPTH`, 2, command FIFO depth; power of 2, ≥ 2.
- `ERRW`, 8, error counter width; used only with the macro.

Ports:
- `main_clk_i`  in  1  clock
- `main_rst_i`  in  1  reset, synchronous, active-high
- `cmd_valid_i`  in  1  command valid
- `cmd_ready_o`  out  1  command ready, equals FIFO not full
- `cmd_addr_i`  in  AW  word address
- `cmd_wena_i`  in  1  1 = write, 0 = read
- `cmd_wdata_i`  in  DW  write data
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  response ready
- `rsp_wena_o`  out  1  echo of the command type
- `rsp_rdata_o`  out  DW  read data; 0 for writes
- `rsp_err_o`  out  1  target reported an error
- `mem_ena_o`  out  1  access strobe, high for exactly 1 cycle per access
- `mem_addr_o`  out  AW  access address
- `mem_wena_o`  out  1  write enable
- `mem_wdata_o`  out  DW  write data
- `mem_rdata_i`  in  DW  read data, valid in the cycle after `mem_ena_o`
- `mem_err_i`  in  1  error flag, valid in the cycle after `mem_ena_o`
- `busy_o`  out  1  high when the FSM is not IDLE or the FIFO is not empty
- `errcnt_o`  out  ERRW  saturating error count; present only with the macro

## Operation
Command FIFO:
- Push on `cmd_valid_i && cmd_ready_o`.
- Pop only by the FSM.
- When full, `cmd_ready_o` is 0; a push is not possible in that cycle even if a pop occurs.

FSM states:
- IDLE: if the FIFO is not empty, pop it, load the `mem_addr/wena/wdata` registers, and go to REQ.
- REQ: `mem_ena_o`=1. Go to WAIT.
- WAIT: capture `mem_rdata_i` and `mem_err_i` into the response registers; force `rsp_rdata_o` to 0 when `wena`=1. Go to RESP.
- RESP: `rsp_valid_o`=1, and the response is held stable until `rsp_ready_i`.
  - On handshake with the FIFO not empty: pop, load, and go to REQ.
  - On handshake with the FIFO empty: go to IDLE.

Output behaviour:
- `mem_addr_o`, `mem_wena_o` and `mem_wdata_o` are registered. They hold their last value outside REQ.
- `mem_wena_o` is forced to 0 whenever `mem_ena_o`=0.
- Errors do not stop processing. Every command gets exactly one response, in command order.

Reset values:
- `cmd_ready_o`=1 (combinational from count; no pushes are taken while `main_rst_i`=1).
- All other outputs are 0: `rsp_valid_o`, `rsp_*`, `mem_ena_o`, `mem_addr_o`, `mem_wena_o`, `mem_wdata_o`, `busy_o`, `errcnt_o`.

Reset asserted mid-operation:
- The FIFO is emptied and the FSM goes to IDLE at the next edge.
- Any in-flight access produces no response.
- `mem_ena_o` is 0 from the cycle after the reset edge.

## Timing
- Command handshake in cycle 0 → IDLE pop in cycle 1 → `mem_ena_o` in cycle 2 → capture in cycle 3 → `rsp_valid_o` in cycle 4.
- Back-to-back commands with `rsp_ready_i`=1 yield one access every 3 cycles (RESP→REQ→WAIT→RESP).
- `rsp_ready_i` low stalls the FSM in RESP. The FIFO keeps accepting commands until it is full.

## Configuration
`REGF_INITIATOR_ERRCNT_EN`:
- Defined: `errcnt_o` exists. It increments by 1 at each response handshake with `rsp_err_o`=1, saturates at 2^ERRW−1, and is cleared only by reset.
- Undefined: the port and the counter are absent, and the behaviour is otherwise identical.

## Structure
- `regf_initiator_pkg` holds:
  - the `state_e` enum (IDLE, REQ, WAIT, RESP);
  - the `cmd_t` struct (addr, wena, wdata);
  - the `rsp_t` struct (wena, rdata, err).
- Sub-module `regf_initiator_fifo`: a synchronous FIFO of `cmd_t`, parameterised by DEPTH, with full/empty flags and sync reset.

## Test plan
- Write then read: write 0x004←0xDEADBEEF, then read 0x004 with the target returning 0xDEADBEEF.
  - `mem_ena_o` pulses in cycles 2 and 5.
  - Responses are `wena`=1/`rdata`=0, then `wena`=0/`rdata`=0xDEADBEEF.
  - First `rsp_valid_o` appears in cycle 4.
- Burst and fill: send 4 commands with `rsp_ready_i`=0 and DEPTH=2.
  - `cmd_ready_o` drops after the FIFO is full.
  - Exactly 1 `mem_ena_o` pulse occurs.
  - After `rsp_ready_i`=1, 4 in-order responses arrive, 3 cycles apart.
- Error: target drives `mem_err_i`=1 on a read of 0x1FFF.
  - `rsp_err_o`=1.
  - `errcnt_o` goes 0→1 with the macro; a further 300 errors saturate it at 255.
- Reset mid-access: assert `main_rst_i` in the REQ cycle with 2 commands queued.
  - No response is produced and `busy_o`=0 after the reset edge.
  - `mem_ena_o`=0 thereafter.
  - The next command completes normally.
- Stall stability: hold `rsp_ready_i`=0 for 10 cycles.
  - `rsp_*` are stable.
  - `mem_ena_o` stays 0 throughout.
